// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) with start/busy/done handshake.
// Optional MULDIV_EARLY_ZERO_EN: trivially-zero operations skip RUN and go straight to FIXUP.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               quo_neg_q, quo_neg_d;
    logic [WIDTH-1:0]   ph_q, ph_d;
    logic [WIDTH-1:0]   pl_q, pl_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_shift;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;
    logic               early_zero;

    // Datapath helpers: Booth adder is WIDTH+1 bits so subtracting the most negative a cannot overflow.
    always_comb begin
        a_mag     = a[WIDTH-1] ? -a : a;
        b_mag     = b[WIDTH-1] ? -b : b;
        booth_sum = {ph_q[WIDTH-1], ph_q};
        case ({pl_q[0], q1_q})
            2'b01:   booth_sum = {ph_q[WIDTH-1], ph_q} + {a_q[WIDTH-1], a_q};
            2'b10:   booth_sum = {ph_q[WIDTH-1], ph_q} - {a_q[WIDTH-1], a_q};
            default: booth_sum = {ph_q[WIDTH-1], ph_q};
        endcase
        // Remainder stays below |b| <= 2^(WIDTH-1), so its top bit is always zero before the shift.
        rem_shift = {ph_q[WIDTH-2:0], pl_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {1'b0, dvs_q};
        accept    = start && ((state_q == IDLE) || (state_q == DONE));
`ifdef MULDIV_EARLY_ZERO_EN
        early_zero = op ? ((a == '0) && (b != '0)) : ((a == '0) || (b == '0));
`else
        early_zero = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        ph_d      = ph_q;
        pl_d      = pl_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d      = op;
                    a_d       = a;
                    dvs_d     = b_mag;
                    quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    q1_d      = 1'b0;
                    ph_d      = '0;
                    pl_d      = op ? a_mag : b;
                    state_d   = RUN;
                    if (early_zero) begin
                        pl_d    = '0;
                        state_d = FIXUP;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!op_q) begin
                    ph_d = booth_sum[WIDTH:1];
                    pl_d = {booth_sum[0], pl_q[WIDTH-1:1]};
                    q1_d = pl_q[0];
                end else if (!trial[WIDTH]) begin
                    ph_d = trial[WIDTH-1:0];
                    pl_d = {pl_q[WIDTH-2:0], 1'b1};
                end else begin
                    ph_d = rem_shift;
                    pl_d = {pl_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = DONE;
                if (!op_q) begin
                    hi_d = ph_q;
                    lo_d = pl_q;
                end else if (dvs_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = a_q[WIDTH-1] ? -ph_q : ph_q;
                    lo_d = quo_neg_q ? -pl_q : pl_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            a_q       <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            ph_q      <= '0;
            pl_q      <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            ph_q      <= ph_d;
            pl_q      <= pl_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIXUP);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes hand-computed results, a monitor pops them on each done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           doneCyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busyCnt;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Edge counter: value after a posedge is that edge's index.
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; the following posedge is edge 0 of the operation.
    task automatic applyStimulus(input logic opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                 input logic [W-1:0] expHi, input logic [W-1:0] expLo, input logic expDbz,
                                 input bit track, input int lat, input string name);
        exp_t e;
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        if (track) begin
            e.hi      = expHi;
            e.lo      = expLo;
            e.dbz     = expDbz;
            e.doneCyc = cyc + 1 + lat;
            e.name    = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is seen, counting busy cycles on the way.
    task automatic waitDone(output int bc);
        bit found = 0;
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
            if (busy === 1'b1) bc++;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout cyc=%0d expected done within 200 cycles", cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation, including its timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done cyc=%0d actual=done expected=no_done", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_hi"}, hi, e.hi);
                    checkOutput({e.name, "_lo"}, lo, e.lo);
                    checkOutput({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
                    checkOutput({e.name, "_done_cycle"}, W'(cyc), W'(e.doneCyc));
                end
            end
        end
    end

    initial begin
        int zeroLat;
`ifdef MULDIV_EARLY_ZERO_EN
        zeroLat = 1;
`else
        zeroLat = W + 1;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", W'(busy), 0);
        checkOutput("reset_done", W'(done), 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_dbz", W'(div_by_zero), 0);
        clear = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, W + 1, "mul_7x-3");
        waitDone(busyCnt);
        checkOutput("mul_busy_cycles", W'(busyCnt), W'(W + 1));

        @(negedge clk);
        applyStimulus(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1, W + 1, "mul_maxpos");
        waitDone(busyCnt);
        @(negedge clk);
        applyStimulus(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1, W + 1, "mul_maxneg");
        waitDone(busyCnt);
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1, W + 1, "div_-7by2");
        waitDone(busyCnt);
        @(negedge clk);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1, W + 1, "div_minby-1");
        waitDone(busyCnt);
        @(negedge clk);
        applyStimulus(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, W + 1, "div_by_zero");
        waitDone(busyCnt);

        // The next accepted start must clear the flag right at edge 0.
        @(negedge clk);
        applyStimulus(1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30, 1'b0, 1, W + 1, "mul_-5x-6");
        checkOutput("dbz_cleared_at_start", W'(div_by_zero), 0);
        waitDone(busyCnt);

        // Back-to-back: start during the DONE cycle.
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 1, W + 1, "div_b2b_-100by7");
        checkOutput("b2b_busy_after_edge0", W'(busy), 1);
        waitDone(busyCnt);
        checkOutput("b2b_busy_cycles", W'(busyCnt), W'(W + 1));

        @(negedge clk);
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1, W + 1, "div_7by-2");
        waitDone(busyCnt);

        // A second start at edge 5 and operand changes while busy must be ignored.
        @(negedge clk);
        applyStimulus(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1, W + 1, "mul_6x7_ignore");
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd99;
        b     = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(busyCnt);

        // Reset at edge 10 of a running multiply: outputs drop at once and no done follows.
        @(negedge clk);
        applyStimulus(1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 0, W + 1, "mul_aborted");
        repeat (10) @(posedge clk);
        #2 clear = 1'b0;
        #1;
        checkOutput("abort_busy", W'(busy), 0);
        checkOutput("abort_done", W'(done), 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        checkOutput("abort_dbz", W'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, W + 1, "div_100by7");
        waitDone(busyCnt);

        @(negedge clk);
        applyStimulus(1'b0, 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 1, zeroLat, "mul_0x9");
        waitDone(busyCnt);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", W'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
